// File: rtl/memory.sv
// Memory pipeline stage: issues aligned load/store requests on the data bus,
// formats store lanes / load results, and registers the writeback and branch redirect.
module memory (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // execute stage
    input  logic [5:0]  i_exec_mem_rd,
    input  logic        i_exec_mem_writeback,
    input  logic        i_exec_mem_link,
    input  logic [31:0] i_exec_mem_pc,
    input  logic        i_exec_mem_mem_w,
    input  logic        i_exec_mem_mem_r,
    input  logic        i_exec_mem_mem_rdu,
    input  logic        i_exec_mem_mem_byte,
    input  logic        i_exec_mem_mem_hwrd,
    input  logic [31:0] i_exec_mem_alu_result,
    input  logic [31:0] i_exec_mem_mem_wdata,
    input  logic [31:0] i_exec_mem_bta,
    input  logic        i_exec_mem_branch_taken,
    // data bus
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    // pipeline control
    output logic        o_mem_stall,
    output logic        o_mem_misaligned,
    // writeback / fetch
    output logic [5:0]  b_mem_wb_rd,
    output logic        b_mem_wb_writeback,
    output logic [31:0] b_mem_wb_result,
    output logic        b_mem_fetch_redirect,
    output logic [31:0] b_mem_fetch_bta
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RDW  = 6;
    localparam int unsigned BEW  = 4;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [BEW-1:0]    be_q, be_d;
    logic [1:0]        ld_lane_q, ld_lane_d;
    logic              ld_byte_q, ld_byte_d;
    logic              ld_hwrd_q, ld_hwrd_d;
    logic              ld_rdu_q, ld_rdu_d;
    logic [RDW-1:0]    ld_rd_q, ld_rd_d;
    logic              ld_wb_q, ld_wb_d;
    logic [RDW-1:0]    wb_rd_q, wb_rd_d;
    logic              wb_writeback_q, wb_writeback_d;
    logic [XLEN-1:0]   wb_result_q, wb_result_d;
    logic              redirect_q, redirect_d;
    logic [XLEN-1:0]   bta_q, bta_d;

    logic              access_c;
    logic              aligned_c;
    logic              stall_c;
    logic              misaligned_c;
    logic [BEW-1:0]    lane_be_c;
    logic [XLEN-1:0]   store_wdata_c;
    logic [XLEN-1:0]   nonmem_result_c;
    logic [XLEN-1:0]   rdata_shift_c;
    logic [XLEN-1:0]   load_data_c;

    assign access_c        = i_exec_mem_mem_r | i_exec_mem_mem_w;
    assign nonmem_result_c = i_exec_mem_link ? (i_exec_mem_pc + XLEN'(4)) : i_exec_mem_alu_result;

    // Alignment check and store lane formatting; byte size wins over halfword.
    always_comb begin
        aligned_c     = 1'b1;
        lane_be_c     = 4'b1111;
        store_wdata_c = i_exec_mem_mem_wdata;
        if (i_exec_mem_mem_byte) begin
            lane_be_c     = BEW'(1) << i_exec_mem_alu_result[1:0];
            store_wdata_c = {4{i_exec_mem_mem_wdata[7:0]}};
        end else if (i_exec_mem_mem_hwrd) begin
            aligned_c     = ~i_exec_mem_alu_result[0];
            lane_be_c     = i_exec_mem_alu_result[1] ? 4'b1100 : 4'b0011;
            store_wdata_c = {2{i_exec_mem_mem_wdata[15:0]}};
        end else begin
            aligned_c     = (i_exec_mem_alu_result[1:0] == 2'b00);
        end
    end

    // Load lane select and extension, using the access attributes captured at issue.
    assign rdata_shift_c = i_dmem_rdata >> {ld_lane_q, 3'b000};

    always_comb begin
        load_data_c = i_dmem_rdata;
        if (ld_byte_q) begin
            load_data_c = ld_rdu_q ? {24'd0, rdata_shift_c[7:0]}
                                   : {{24{rdata_shift_c[7]}}, rdata_shift_c[7:0]};
        end else if (ld_hwrd_q) begin
            load_data_c = ld_rdu_q ? {16'd0, rdata_shift_c[15:0]}
                                   : {{16{rdata_shift_c[15]}}, rdata_shift_c[15:0]};
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        ld_lane_d      = ld_lane_q;
        ld_byte_d      = ld_byte_q;
        ld_hwrd_d      = ld_hwrd_q;
        ld_rdu_d       = ld_rdu_q;
        ld_rd_d        = ld_rd_q;
        ld_wb_d        = ld_wb_q;
        wb_rd_d        = i_exec_mem_rd;
        wb_writeback_d = 1'b0;
        wb_result_d    = nonmem_result_c;
        bta_d          = i_exec_mem_bta;
        stall_c        = 1'b0;
        misaligned_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access_c) begin
                    if (aligned_c) begin
                        stall_c   = 1'b1;
                        state_d   = S_ACCESS;
                        req_d     = 1'b1;
                        we_d      = i_exec_mem_mem_w;
                        addr_d    = {i_exec_mem_alu_result[31:2], 2'b00};
                        wdata_d   = store_wdata_c;
                        be_d      = lane_be_c;
                        ld_lane_d = i_exec_mem_alu_result[1:0];
                        ld_byte_d = i_exec_mem_mem_byte;
                        ld_hwrd_d = i_exec_mem_mem_hwrd;
                        ld_rdu_d  = i_exec_mem_mem_rdu;
                        ld_rd_d   = i_exec_mem_rd;
                        // stores never write back, even when mem_r is also set
                        ld_wb_d   = i_exec_mem_writeback & ~i_exec_mem_mem_w;
                    end else begin
                        misaligned_c = 1'b1;
                    end
                end else begin
                    wb_writeback_d = i_exec_mem_writeback;
                end
            end
            S_ACCESS: begin
                if (i_dmem_ack) begin
                    state_d        = S_IDLE;
                    req_d          = 1'b0;
                    we_d           = 1'b0;
                    wb_rd_d        = ld_rd_q;
                    wb_writeback_d = ld_wb_q;
                    wb_result_d    = load_data_c;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase

        redirect_d = i_exec_mem_branch_taken & ~stall_c;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            ld_lane_q      <= '0;
            ld_byte_q      <= 1'b0;
            ld_hwrd_q      <= 1'b0;
            ld_rdu_q       <= 1'b0;
            ld_rd_q        <= '0;
            ld_wb_q        <= 1'b0;
            wb_rd_q        <= '0;
            wb_writeback_q <= 1'b0;
            wb_result_q    <= '0;
            redirect_q     <= 1'b0;
            bta_q          <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            ld_lane_q      <= ld_lane_d;
            ld_byte_q      <= ld_byte_d;
            ld_hwrd_q      <= ld_hwrd_d;
            ld_rdu_q       <= ld_rdu_d;
            ld_rd_q        <= ld_rd_d;
            ld_wb_q        <= ld_wb_d;
            wb_rd_q        <= wb_rd_d;
            wb_writeback_q <= wb_writeback_d;
            wb_result_q    <= wb_result_d;
            redirect_q     <= redirect_d;
            bta_q          <= bta_d;
        end
    end

    assign o_dmem_req           = req_q;
    assign o_dmem_we            = we_q;
    assign o_dmem_addr          = addr_q;
    assign o_dmem_wdata         = wdata_q;
    assign o_dmem_be            = be_q;
    assign o_mem_stall          = stall_c;
    assign o_mem_misaligned     = misaligned_c;
    assign b_mem_wb_rd          = wb_rd_q;
    assign b_mem_wb_writeback   = wb_writeback_q;
    assign b_mem_wb_result      = wb_result_q;
    assign b_mem_fetch_redirect = redirect_q;
    assign b_mem_fetch_bta      = bta_q;

endmodule
